apb_fsm_controller: RTL

- Downstream stage of the AHB slave interface in the AHB-to-APB bridge.
- Consumes the decoded `valid`, `tempselx` and AHB address-phase signals, and sequences one APB transfer (SETUP then ACCESS) per AHB transfer.
- Drives `Hreadyout`, `Hresp` and `Hrdata` back to the AHB side; `Hreadyout` is also fed back as `Hreadyin`.
- Non-pipelined: exactly one outstanding transfer at a time.

---
 rtl/apb_fsm_controller.sv | 129 ++++++++++++
 1 files changed

// File: rtl/apb_fsm_controller.sv
// ============================================================================
// apb_fsm_controller : sequences one APB SETUP/ACCESS transfer per AHB transfer
// Revision: 1.0
// ============================================================================
`default_nettype none

module apb_fsm_controller #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int NSLV   = 3
) (
  input  logic              Hclk,
  input  logic              Hresetn,
  input  logic              valid,
  input  logic [NSLV-1:0]   tempselx,
  input  logic [ADDR_W-1:0] Haddr,
  input  logic              Hwrite,
  input  logic [DATA_W-1:0] Hwdata,
  input  logic              Pready,
  input  logic              Pslverr,
  input  logic [DATA_W-1:0] Prdata,
  output logic [NSLV-1:0]   Pselx,
  output logic              Penable,
  output logic              Pwrite,
  output logic [ADDR_W-1:0] Paddr,
  output logic [DATA_W-1:0] Pwdata,
  output logic              Hreadyout,
  output logic [1:0]        Hresp,
  output logic [DATA_W-1:0] Hrdata
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_WLATCH = 3'd1,
    S_SETUP  = 3'd2,
    S_ACCESS = 3'd3,
    S_ERR1   = 3'd4,
    S_ERR2   = 3'd5
  } state_t;

  localparam logic [1:0] c_RESP_OKAY  = 2'b00;
  localparam logic [1:0] c_RESP_ERROR = 2'b01;

  state_t          r_state;
  logic [NSLV-1:0] r_sel;
  logic            w_access_done;
  logic            w_accept;

  assign w_access_done = (r_state == S_ACCESS) && Pready && !Pslverr;
  // A completing ACCESS may hand straight over to the next transfer.
  assign w_accept      = valid && ((r_state == S_IDLE) || w_access_done);

  always_ff @(posedge Hclk or negedge Hresetn) begin
    if (!Hresetn) begin
      r_state <= S_IDLE;
      r_sel   <= '0;
      Pselx   <= '0;
      Penable <= 1'b0;
      Pwrite  <= 1'b0;
      Paddr   <= '0;
      Pwdata  <= '0;
    end else if (w_accept) begin
      Paddr   <= Haddr;
      Pwrite  <= Hwrite;
      r_sel   <= tempselx;
      Penable <= 1'b0;
      if (tempselx == '0) begin
        r_state <= S_ERR1;
        Pselx   <= '0;
      end else if (Hwrite) begin
        r_state <= S_WLATCH;
        Pselx   <= '0;
      end else begin
        r_state <= S_SETUP;
        Pselx   <= tempselx;
      end
    end else begin
      case (r_state)
        S_IDLE: begin
          Pselx   <= '0;
          Penable <= 1'b0;
        end
        S_WLATCH: begin
          Pwdata  <= Hwdata;
          Pselx   <= r_sel;
          Penable <= 1'b0;
          r_state <= S_SETUP;
        end
        S_SETUP: begin
          Penable <= 1'b1;
          r_state <= S_ACCESS;
        end
        S_ACCESS: begin
          if (Pready) begin
            Pselx   <= '0;
            Penable <= 1'b0;
            r_state <= Pslverr ? S_ERR1 : S_IDLE;
          end
        end
        S_ERR1: begin
          r_state <= S_ERR2;
        end
        S_ERR2: begin
          r_state <= S_IDLE;
        end
        default: begin
          Pselx   <= '0;
          Penable <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  always_comb begin
    Hreadyout = 1'b0;
    case (r_state)
      S_IDLE, S_ERR2: Hreadyout = 1'b1;
      S_ACCESS:       Hreadyout = Pready && !Pslverr;
      default:        Hreadyout = 1'b0;
    endcase
  end

  assign Hresp  = ((r_state == S_ERR1) || (r_state == S_ERR2)) ? c_RESP_ERROR : c_RESP_OKAY;
  assign Hrdata = Prdata;

endmodule

`default_nettype wire
